wb_group_arbiter: RTL and testbench

- Shares one multicycle writeback port (writeback group 1) among several multicycle execution units (e.g. mul, div, load/store, custom).
- Picks at most one completing unit per cycle using round-robin priority and acknowledges it in the same cycle.
- Registers the winner's ID and result onto the group's wb_packet, which feeds commit and clears the ID's waiting-for-writeback state.
- Has no backpressure from downstream; the writeback port accepts every cycle.

---
 rtl/wb_group_arbiter.sv | 99 +++++++++
 tb/tb_wb_group_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_group_arbiter.sv
// Round-robin arbiter sharing one writeback port among several multicycle units.
// The grant is combinational and acks the winner in the same cycle; the winner's packet is registered.
module wb_group_arbiter #(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_UNITS-1:0]                unit_done,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]      unit_id,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]    unit_rd,
  output logic [NUM_UNITS-1:0]                unit_ack,
  output logic                                wb_valid,
  output logic [ID_W-1:0]                     wb_id,
  output logic [DATA_W-1:0]                   wb_data,
  output logic [CNT_W-1:0]                    conflict_count
);

  localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(NUM_UNITS - 1);
  localparam logic [PTR_W:0]   NumUnitsW = (PTR_W + 1)'(NUM_UNITS);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_vld;
  logic              conflict;
  logic              wb_valid_q;
  logic [ID_W-1:0]   wb_id_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [CNT_W-1:0]  conflict_q;

  // Scan from the pointer upward; ptr + k < 2*NUM_UNITS, so one subtraction wraps it.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    unit_ack  = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (sum >= NumUnitsW) begin
        sum = sum - NumUnitsW;
      end
      idx = sum[PTR_W-1:0];
      if (!grant_vld && unit_done[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = idx;
        unit_ack[idx] = 1'b1;
      end
    end
    if (rst) begin
      grant_vld = 1'b0;
      unit_ack  = '0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end
  end

  assign conflict = ($countones(unit_done) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_data_q  <= '0;
      conflict_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= grant_vld;
      if (grant_vld) begin
        wb_id_q   <= unit_id[grant_idx];
        wb_data_q <= unit_rd[grant_idx];
      end
      if (conflict && (conflict_q != '1)) begin
        conflict_q <= conflict_q + 1'b1;
      end
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_id          = wb_id_q;
  assign wb_data        = wb_data_q;
  assign conflict_count = conflict_q;

  a_ack_onehot: assert property (@(posedge clk) $onehot0(unit_ack));
  a_ack_has_req: assert property (@(posedge clk) (unit_ack & ~unit_done) == '0);
  a_no_wb_after_rst: assert property (@(posedge clk) rst |=> !wb_valid);

endmodule

// File: tb/tb_wb_group_arbiter.sv
// Scoreboard bench for wb_group_arbiter: a reference model predicts acks and writeback
// packets per cycle; a separate monitor compares the registered outputs.
module tb_wb_group_arbiter;

  localparam int N    = 3;
  localparam int IDW  = 3;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            unit_done;
  logic [N-1:0][IDW-1:0]   unit_id;
  logic [N-1:0][DW-1:0]    unit_rd;
  logic [N-1:0]            unit_ack;
  logic                    wb_valid;
  logic [IDW-1:0]          wb_id;
  logic [DW-1:0]           wb_data;
  logic [CW-1:0]           conflict_count;

  always #5 clk = ~clk;

  wb_group_arbiter #(
    .NUM_UNITS(N),
    .ID_W     (IDW),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .unit_done     (unit_done),
    .unit_id       (unit_id),
    .unit_rd       (unit_rd),
    .unit_ack      (unit_ack),
    .wb_valid      (wb_valid),
    .wb_id         (wb_id),
    .wb_data       (wb_data),
    .conflict_count(conflict_count)
  );

  typedef struct {
    logic           v;
    logic [IDW-1:0] id;
    logic [DW-1:0]  d;
    int             cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state
  int             m_ptr  = 0;
  int             m_cnt  = 0;
  logic [IDW-1:0] m_id   = '0;
  logic [DW-1:0]  m_data = '0;
  logic [N-1:0]   m_ack  = '0;

  // One clock cycle: inputs are already applied; predict, check ack, queue the packet.
  task automatic cycle(input logic r);
    exp_t e;
    int   g;
    int   pc;
    rst = r;
    @(negedge clk);
    m_ack = '0;
    g     = -1;
    pc    = 0;
    for (int i = 0; i < N; i++) if (unit_done[i]) pc++;
    if (r) begin
      m_ptr  = 0;
      m_cnt  = 0;
      m_id   = '0;
      m_data = '0;
      e.v    = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && unit_done[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      e.v = (g >= 0);
      if (g >= 0) begin
        m_ack[g] = 1'b1;
        m_id     = unit_id[g];
        m_data   = unit_rd[g];
        m_ptr    = (g + 1) % N;
      end
      if (pc >= 2 && m_cnt < CMAX) m_cnt++;
    end
    e.id  = m_id;
    e.d   = m_data;
    e.cnt = m_cnt;
    vectors++;
    if (unit_ack !== m_ack) begin
      miscompares++;
      $display("FAIL ack: got %b expected %b (done=%b rst=%b) at %0t",
               unit_ack, m_ack, unit_done, r, $time);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    unit_done[i] = 1'b1;
    unit_id[i]   = IDW'($urandom);
    unit_rd[i]   = $urandom;
  endtask

  // Acked units either present a fresh result or go idle.
  task automatic react(input bit keep_all);
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        if (keep_all || $urandom_range(0, 1) == 1) new_req(i);
        else unit_done[i] = 1'b0;
      end else if (!keep_all && !unit_done[i] && $urandom_range(0, 2) == 0) begin
        new_req(i);
      end
    end
  endtask

  // Monitor: compares registered outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (wb_valid !== e.v || wb_id !== e.id || wb_data !== e.d ||
            conflict_count !== CW'(e.cnt)) begin
          miscompares++;
          $display("FAIL wb: got v=%b id=%0d data=%h cnt=%0d expected v=%b id=%0d data=%h cnt=%0d at %0t",
                   wb_valid, wb_id, wb_data, conflict_count, e.v, e.id, e.d, e.cnt, $time);
        end
      end
    end
  end

  initial begin
    logic r;
    rst       = 1'b1;
    unit_done = '0;
    unit_id   = '0;
    unit_rd   = '0;
    @(posedge clk);
    #1;
    cycle(1'b1);
    cycle(1'b1);

    // Single requester on unit 1
    unit_done    = 3'b010;
    unit_id[1]   = 3'd5;
    unit_rd[1]   = 32'hDEADBEEF;
    cycle(1'b0);
    unit_done = '0;
    cycle(1'b0);

    // Pointer at 2, unit 2 idle: wraps to unit 0, then unit 1
    new_req(0);
    new_req(1);
    cycle(1'b0);
    unit_done = 3'b010;
    cycle(1'b0);

    // Idle cycles: outputs hold, counter holds
    unit_done = '0;
    repeat (4) cycle(1'b0);

    // All units requesting right after reset
    cycle(1'b1);
    for (int i = 0; i < N; i++) new_req(i);
    repeat (5) begin
      cycle(1'b0);
      react(1'b1);
    end

    // Move pointer to 1, then reset while units 1 and 2 wait
    unit_done = 3'b001;
    cycle(1'b0);
    unit_done = 3'b110;
    cycle(1'b1);
    cycle(1'b0);
    unit_done = '0;
    cycle(1'b0);

    // Counter saturation
    for (int i = 0; i < N; i++) new_req(i);
    repeat (20) begin
      cycle(1'b0);
      react(1'b1);
    end

    // Randomized traffic with occasional reset
    unit_done = '0;
    repeat (400) begin
      r = ($urandom_range(0, 49) == 0);
      cycle(r);
      react(1'b0);
    end
    unit_done = '0;
    cycle(1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #4;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
